atd_deserializer: RTL and testbench

- Upstream neighbour of the data register input mux; it produces the 128-bit `ATD_parallel` word consumed there.
- Collects an incoming byte stream into one 128-bit block, MSB-first.
- Flags the block valid and holds it stable until the controller acknowledges it.
- Applies backpressure to the byte source while a completed block is pending.

---
 rtl/atd_pkg.sv | 15 +
 rtl/atd_byte_counter.sv | 30 +++
 rtl/atd_deserializer.sv | 132 +++++++++++++
 tb/tb_atd_deserializer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/atd_pkg.sv
// Shared types and constants for the ATD byte-to-block deserializer.
//   atd_state_t     : FILL (collecting bytes) / FULL (block pending ack)
//   ATD_BLOCK_BYTES : bytes per assembled block
//   ATD_BLOCK_W     : width of the assembled block in bits
package atd_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } atd_state_t;

    localparam int ATD_BLOCK_BYTES = 16;
    localparam int ATD_BLOCK_W     = 128;

endpackage

// File: rtl/atd_byte_counter.sv
// 4-bit byte counter for the ATD deserializer.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : synchronous active-low reset
//   clr   : synchronous clear to zero (wins over en)
//   en    : count one byte this cycle
//   count : bytes counted so far (0..15)
//   wrap  : en while count==15; this edge completes a block and count rolls to 0
module atd_byte_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic       wrap
);

    assign wrap = en && (count == 4'hF);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;   // natural 4-bit rollover on the 16th byte
        end
    end

endmodule

// File: rtl/atd_deserializer.sv
// Collects a byte stream MSB-first into one 128-bit block, flags it valid and
// holds it stable (with byte backpressure) until the controller acknowledges.
//
// Ports:
//   clk, n_rst   : clock (rising edge), synchronous active-low reset
//   byte_in      : incoming byte; byte_valid marks it valid this cycle
//   byte_ready   : high in FILL; a byte is accepted on byte_valid && byte_ready
//   block_ack    : controller took ATD_parallel (only acted on in FULL)
//   clear        : synchronous abort of the partial block, clears overrun_err
//   flush        : pad-and-complete request (active only with ATD_FLUSH_EN)
//   ATD_parallel : assembled block, first byte in the top byte lane
//   block_valid  : high in FULL
//   byte_count   : bytes accepted into the current block
//   overrun_err  : sticky, set by byte_valid while a block is pending
//
// Valid/ready: a byte transfers exactly on a rising edge where byte_valid and
// byte_ready are both high; byte_ready depends only on registered state.
//
// Build option: define ATD_FLUSH_EN to enable the flush input; otherwise it is
// ignored.
module atd_deserializer
    import atd_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int BYTE_W    = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [BYTE_W-1:0]           byte_in,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    input  logic                        block_ack,
    input  logic                        clear,
    input  logic                        flush,
    output logic [NUM_BYTES*BYTE_W-1:0] ATD_parallel,
    output logic                        block_valid,
    output logic [3:0]                  byte_count,
    output logic                        overrun_err
);

    localparam int W = NUM_BYTES * BYTE_W;

    atd_state_t     state, next_state;
    logic [W-1:0]   data_q;
    logic [W-1:0]   shift_data;
    logic           accept;
    logic           wrap;
    logic           flush_fire;

    assign accept     = byte_valid && (state == FILL);
    assign shift_data = {data_q[W-BYTE_W-1:0], byte_in};

    atd_byte_counter u_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clear || flush_fire),
        .en    (accept && !clear),
        .count (byte_count),
        .wrap  (wrap)
    );

`ifdef ATD_FLUSH_EN
    // Bytes in the block after this edge, counting a byte accepted alongside
    // the flush; the block is then left-justified with zero padding.
    logic [4:0]   fill_bytes;
    logic [W-1:0] flush_src;
    logic [W-1:0] flush_data;

    assign fill_bytes = {1'b0, byte_count} + {4'd0, accept};
    assign flush_src  = accept ? shift_data : data_q;
    assign flush_data = flush_src << (BYTE_W * (NUM_BYTES - int'(fill_bytes)));
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

    always_comb begin
        next_state = state;
        flush_fire = 1'b0;
        case (state)
            FILL: begin
                if (wrap) begin
                    next_state = FULL;
`ifdef ATD_FLUSH_EN
                end else if (flush && (byte_count != 4'd0 || accept)) begin
                    flush_fire = 1'b1;
                    next_state = FULL;
`endif
                end
            end
            FULL: begin
                if (block_ack) next_state = FILL;
            end
            default: next_state = FILL;
        endcase
        if (clear) next_state = FILL;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= FILL;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_q <= '0;
        end else if (clear) begin
            data_q <= '0;
`ifdef ATD_FLUSH_EN
        end else if (flush_fire) begin
            data_q <= flush_data;
`endif
        end else if (accept) begin
            data_q <= shift_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overrun_err <= 1'b0;
        end else if (clear) begin
            overrun_err <= 1'b0;
        end else if (state == FULL && byte_valid) begin
            overrun_err <= 1'b1;
        end
    end

    assign byte_ready   = (state == FILL);
    assign block_valid  = (state == FULL);
    assign ATD_parallel = data_q;

endmodule

// File: tb/tb_atd_deserializer.sv
// Directed testbench for atd_deserializer. Inputs change 1 ns after a rising
// edge; outputs are checked 1 ns after the edge that registered them.
module tb_atd_deserializer;

    logic         clk;
    logic         n_rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         block_ack;
    logic         clear;
    logic         flush;
    logic [127:0] ATD_parallel;
    logic         block_valid;
    logic [3:0]   byte_count;
    logic         overrun_err;

    int tests_run = 0;
    int tests_failed = 0;

    atd_deserializer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .block_ack    (block_ack),
        .clear        (clear),
        .flush        (flush),
        .ATD_parallel (ATD_parallel),
        .block_valid  (block_valid),
        .byte_count   (byte_count),
        .overrun_err  (overrun_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},  ATD_parallel, 128'd0);
        chk({tag, "_count"}, {124'd0, byte_count}, 128'd0);
        chk({tag, "_bv"},    {127'd0, block_valid}, 128'd0);
        chk({tag, "_rdy"},   {127'd0, byte_ready}, 128'd1);
        chk({tag, "_ovr"},   {127'd0, overrun_err}, 128'd0);
    endtask

    initial begin
        logic [127:0] held;
        int gap;

        n_rst = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        block_ack = 1'b0; clear = 1'b0; flush = 1'b0;
        step(); step();
        n_rst = 1'b1;
        chk_reset_state("reset");

        // 16 back-to-back bytes 0x00..0x0F
        for (int i = 0; i < 15; i++) begin
            byte_in = 8'(i); byte_valid = 1'b1; step();
        end
        chk("b2b_count15", {124'd0, byte_count}, 128'd15);
        chk("b2b_bv_before", {127'd0, block_valid}, 128'd0);
        byte_in = 8'h0F; step(); byte_valid = 1'b0;
        chk("b2b_data", ATD_parallel, 128'h000102030405060708090a0b0c0d0e0f);
        chk("b2b_bv", {127'd0, block_valid}, 128'd1);
        chk("b2b_rdy", {127'd0, byte_ready}, 128'd0);
        chk("b2b_count_wrap", {124'd0, byte_count}, 128'd0);

        // overrun while pending
        byte_in = 8'hAA; byte_valid = 1'b1;
        step(); step(); step();
        byte_valid = 1'b0;
        chk("ovr_data", ATD_parallel, 128'h000102030405060708090a0b0c0d0e0f);
        chk("ovr_err", {127'd0, overrun_err}, 128'd1);
        chk("ovr_bv", {127'd0, block_valid}, 128'd1);
        block_ack = 1'b1; step(); block_ack = 1'b0;
        chk("ack_bv", {127'd0, block_valid}, 128'd0);
        chk("ack_rdy", {127'd0, byte_ready}, 128'd1);
        chk("ack_ovr_sticky", {127'd0, overrun_err}, 128'd1);
        chk("ack_data_held", ATD_parallel, 128'h000102030405060708090a0b0c0d0e0f);

        // 16 bytes with random gaps
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h20 + 8'(i));
            chk($sformatf("gap_count%0d", i), {124'd0, byte_count}, 128'((i + 1) % 16));
            gap = $urandom_range(0, 3);
            if (i < 15) begin
                for (int g = 0; g < gap; g++) step();
                chk($sformatf("gap_hold%0d", i), {124'd0, byte_count}, 128'((i + 1) % 16));
            end
        end
        chk("gap_data", ATD_parallel, 128'h202122232425262728292a2b2c2d2e2f);
        chk("gap_bv", {127'd0, block_valid}, 128'd1);
        block_ack = 1'b1; step(); block_ack = 1'b0;

        // 7 bytes then clear with a concurrent byte
        for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
        chk("clr_pre_count", {124'd0, byte_count}, 128'd7);
        clear = 1'b1; byte_in = 8'hFF; byte_valid = 1'b1; step();
        clear = 1'b0; byte_valid = 1'b0;
        chk_reset_state("clr");
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i));
        chk("clr_next_data", ATD_parallel, 128'h505152535455565758595a5b5c5d5e5f);
        chk("clr_next_bv", {127'd0, block_valid}, 128'd1);
        block_ack = 1'b1; step(); block_ack = 1'b0;

        // flush with 3 bytes
        clear = 1'b1; step(); clear = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("fl_pre_data", ATD_parallel, 128'h112233);
        flush = 1'b1; step(); flush = 1'b0;
`ifdef ATD_FLUSH_EN
        chk("fl_data", ATD_parallel, 128'h11223300000000000000000000000000);
        chk("fl_bv", {127'd0, block_valid}, 128'd1);
        chk("fl_count", {124'd0, byte_count}, 128'd0);
        block_ack = 1'b1; step(); block_ack = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl_empty_ignored", {127'd0, block_valid}, 128'd0);
`else
        chk("fl_ignored_count", {124'd0, byte_count}, 128'd3);
        chk("fl_ignored_bv", {127'd0, block_valid}, 128'd0);
        chk("fl_ignored_data", ATD_parallel, 128'h112233);
`endif

        // reset mid-block with byte_count=9
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h60 + 8'(i));
        chk("rst_pre_count", {124'd0, byte_count}, 128'd9);
        n_rst = 1'b0; step(); n_rst = 1'b1;
        chk_reset_state("rst_mid");

        // block completes with block_ack held during FILL (ignored)
        block_ack = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h70 + 8'(i));
        block_ack = 1'b0;
        held = 128'h707172737475767778797a7b7c7d7e7f;
        chk("ackfill_data", ATD_parallel, held);
        chk("ackfill_bv", {127'd0, block_valid}, 128'd1);
        step();
        chk("pend_bv_hold", {127'd0, block_valid}, 128'd1);
        n_rst = 1'b0; step(); n_rst = 1'b1;
        chk_reset_state("rst_pend");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
